ws2812_frame_sequencer: RTL and testbench

//  Upstream stage of ws2812_rgb_controller: streams one frame of pixels from a sync-read pixel RAM.

---
 rtl/ws2812_frame_sequencer.sv | 180 ++++++++++++++++++
 tb/tb_ws2812_frame_sequencer.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ws2812_frame_sequencer.sv
`timescale 1ns/1ps
// ws2812_frame_sequencer
// Streams one frame of pixels out of a synchronous-read pixel RAM into a
// ws2812_rgb_controller. The controller's TX command is used to hand over each
// pixel. After the last pixel, the block issues a RESET command. It then waits
// out the inter-frame latch gap and pulses done.
//
// Ports
//   clk         system clock, all logic on posedge
//   rst         asynchronous reset, active-high
//   start       one-cycle frame request, ignored while busy
//   num_pixels  frame length (0..2^ADDR_W), sampled when start is accepted
//   pix_addr    pixel RAM read address
//   pix_data    RAM read data {r,g,b}, valid one cycle after pix_addr
//   r, g, b     pixel presented to the controller
//   command     00 IDLE, 01 TX, 10 RESET
//   cmd_wait    controller ready (1) / busy (0)
//   busy        high from accepted start until the end of the done cycle
//   done        one-cycle pulse at end of frame
module ws2812_frame_sequencer #(
    parameter int ADDR_W       = 8,
    parameter int CLK_FREQ_KHZ = 10000,
    parameter int RESET_US     = 300
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W:0]   num_pixels,
    output logic [ADDR_W-1:0] pix_addr,
    input  logic [23:0]       pix_data,
    output logic [7:0]        r,
    output logic [7:0]        g,
    output logic [7:0]        b,
    output logic [1:0]        command,
    input  logic              cmd_wait,
    output logic              busy,
    output logic              done
);

    localparam int RESET_CYCLES = CLK_FREQ_KHZ * RESET_US / 1000;
    localparam int CNT_W        = (RESET_CYCLES > 2) ? $clog2(RESET_CYCLES) : 1;

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RESET_CYCLES - 1);
    localparam logic [ADDR_W:0]  IDX_ONE  = {{ADDR_W{1'b0}}, 1'b1};

    localparam logic [1:0] CMD_IDLE  = 2'b00;
    localparam logic [1:0] CMD_TX    = 2'b01;
    localparam logic [1:0] CMD_RESET = 2'b10;

    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_WAIT_HI,
        S_WAIT_LO,
        S_RST_HI,
        S_RST_LO,
        S_GAP,
        S_DONE
    } state_t;

    state_t            r_state, w_next;
    logic [ADDR_W:0]   r_idx, w_idx_next;
    logic [ADDR_W:0]   r_num, w_num_next;
    logic [ADDR_W:0]   w_idx_inc;
    logic [CNT_W-1:0]  r_cnt, w_cnt_next;
    logic [ADDR_W-1:0] r_addr, w_addr_next;
    logic [23:0]       r_rgb, w_rgb_next;
    logic [1:0]        r_cmd, w_cmd_next;
    logic              r_busy, w_busy_next;
    logic              r_done, w_done_next;

    assign w_idx_inc = r_idx + IDX_ONE;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_num   <= '0;
            r_cnt   <= '0;
            r_addr  <= '0;
            r_rgb   <= '0;
            r_cmd   <= CMD_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_idx   <= w_idx_next;
            r_num   <= w_num_next;
            r_cnt   <= w_cnt_next;
            r_addr  <= w_addr_next;
            r_rgb   <= w_rgb_next;
            r_cmd   <= w_cmd_next;
            r_busy  <= w_busy_next;
            r_done  <= w_done_next;
        end
    end

    always_comb begin
        w_next      = r_state;
        w_idx_next  = r_idx;
        w_num_next  = r_num;
        w_cnt_next  = r_cnt;
        w_addr_next = r_addr;
        w_rgb_next  = r_rgb;
        w_busy_next = r_busy;
        w_cmd_next  = CMD_IDLE;
        w_done_next = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_num_next  = num_pixels;
                    w_idx_next  = '0;
                    w_busy_next = 1'b1;
                    if (num_pixels == '0) begin
                        w_next = S_DONE;
                    end else begin
                        // Address goes out on entry to FETCH so that the
                        // one-cycle RAM latency lands the data in LOAD.
                        w_addr_next = '0;
                        w_next      = S_FETCH;
                    end
                end
            end
            S_FETCH: w_next = S_LOAD;
            S_LOAD: begin
                w_rgb_next = pix_data;
                w_next     = S_WAIT_HI;
            end
            S_WAIT_HI: if (cmd_wait) w_next = S_WAIT_LO;
            S_WAIT_LO: begin
                // cmd_wait falling means the controller has taken the pixel;
                // the next fetch runs while it is still shifting out.
                if (!cmd_wait) begin
                    w_idx_next = w_idx_inc;
                    if (w_idx_inc < r_num) begin
                        w_addr_next = w_idx_inc[ADDR_W-1:0];
                        w_next      = S_FETCH;
                    end else begin
                        w_next = S_RST_HI;
                    end
                end
            end
            S_RST_HI: if (cmd_wait) w_next = S_RST_LO;
            S_RST_LO: begin
                if (!cmd_wait) begin
                    w_cnt_next = '0;
                    w_next     = S_GAP;
                end
            end
            S_GAP: begin
                w_cnt_next = r_cnt + CNT_ONE;
                if (r_cnt == CNT_LAST) w_next = S_DONE;
            end
            S_DONE: begin
                w_busy_next = 1'b0;
                w_next      = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase

        // command and done are registered copies of the next state's decode,
        // so they line up cycle-for-cycle with the state register.
        case (w_next)
            S_WAIT_HI, S_WAIT_LO: w_cmd_next = CMD_TX;
            S_RST_HI, S_RST_LO:   w_cmd_next = CMD_RESET;
            default:              w_cmd_next = CMD_IDLE;
        endcase
        w_done_next = (w_next == S_DONE);
    end

    assign pix_addr    = r_addr;
    assign {r, g, b}   = r_rgb;
    assign command     = r_cmd;
    assign busy        = r_busy;
    assign done        = r_done;

endmodule

// File: tb/tb_ws2812_frame_sequencer.sv
`timescale 1ns/1ps
// Bench for ws2812_frame_sequencer. It uses a pixel RAM model and a
// cmd_wait-driven controller responder. A scoreboard queue holds the
// expected pixel for every TX handshake.
module tb_ws2812_frame_sequencer;

    localparam int ADDR_W = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [ADDR_W:0]   num_pixels;
    logic [ADDR_W-1:0] pix_addr;
    logic [23:0]       pix_data;
    logic [7:0]        r, g, b;
    logic [1:0]        command;
    logic              cmd_wait;
    logic              busy;
    logic              done;

    always #5 clk = ~clk;

    ws2812_frame_sequencer #(
        .ADDR_W      (ADDR_W),
        .CLK_FREQ_KHZ(10000),
        .RESET_US    (1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .num_pixels(num_pixels),
        .pix_addr  (pix_addr),
        .pix_data  (pix_data),
        .r         (r),
        .g         (g),
        .b         (b),
        .command   (command),
        .cmd_wait  (cmd_wait),
        .busy      (busy),
        .done      (done)
    );

    logic [23:0] ram [0:(1<<ADDR_W)-1];
    always @(posedge clk) pix_data <= ram[pix_addr];

    int          n_cmp    = 0;
    int          n_err    = 0;
    int          tx_cnt   = 0;
    int          done_cnt = 0;
    int          gap_len  = -1;
    logic [23:0] exp_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Controller responder: ready (cmd_wait=1) until it sees TX or RESET,
    // then busy for 5 (TX) or 3 (RESET) cycles.
    initial begin : responder
        int          busy_left;
        bit          pending;
        logic [23:0] px;
        cmd_wait  = 1'b1;
        busy_left = 0;
        pending   = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                cmd_wait  = 1'b1;
                busy_left = 0;
                pending   = 1'b0;
            end else if (busy_left > 0) begin
                busy_left--;
                if (busy_left == 0) cmd_wait = 1'b1;
            end else if (pending) begin
                cmd_wait  = 1'b0;
                busy_left = (command == 2'b01) ? 5 : 3;
                pending   = 1'b0;
            end else if (cmd_wait && command == 2'b01) begin
                px = {r, g, b};
                tx_cnt++;
                pending = 1'b1;
                chk("tx_expected_avail", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) chk("tx_pixel", px, exp_q.pop_front());
            end else if (cmd_wait && command == 2'b10) begin
                pending = 1'b1;
            end
        end
    end

    // Frame monitor: done pulses, latch-gap length, r/g/b stability under TX.
    initial begin : monitor
        bit          in_rst;
        int          gap;
        logic [1:0]  prev_cmd;
        logic [23:0] prev_rgb;
        in_rst   = 1'b0;
        gap      = 0;
        prev_cmd = 2'b00;
        prev_rgb = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                in_rst = 1'b0;
                gap    = 0;
            end else begin
                if (command == 2'b01 && prev_cmd == 2'b01)
                    chk("rgb_stable_tx", {r, g, b}, prev_rgb);
                if (command == 2'b10) begin
                    in_rst = 1'b1;
                    gap    = 0;
                end else if (in_rst && done) begin
                    gap_len = gap;
                    in_rst  = 1'b0;
                end else if (in_rst && command == 2'b00) begin
                    gap++;
                end
                if (done) done_cnt++;
            end
            prev_cmd = command;
            prev_rgb = {r, g, b};
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic pulse_start(input int n);
        @(negedge clk);
        num_pixels = (ADDR_W+1)'(n);
        start      = 1'b1;
        @(negedge clk);
        start      = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    initial begin : stimulus
        int          tx0, d0;
        bit          ok;
        logic [ADDR_W-1:0] a0;

        rst        = 1'b1;
        start      = 1'b0;
        num_pixels = '0;
        for (int i = 0; i < (1 << ADDR_W); i++) ram[i] = '0;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_command", command, 2'b00);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_pix_addr", pix_addr, 0);
        chk("rst_rgb", {r, g, b}, 24'h0);
        rst = 1'b0;
        @(negedge clk);

        // Three-pixel frame and start-to-TX latency
        ram[0] = 24'hFF0000; ram[1] = 24'h00FF00; ram[2] = 24'h0000FF;
        exp_q.push_back(24'hFF0000); exp_q.push_back(24'h00FF00); exp_q.push_back(24'h0000FF);
        tx0 = tx_cnt; d0 = done_cnt;
        pulse_start(3);
        chk("t1_busy_after_start", busy, 1'b1);
        chk("t1_cmd_fetch", command, 2'b00);
        @(negedge clk);
        chk("t1_cmd_load", command, 2'b00);
        @(negedge clk);
        chk("t1_cmd_tx_latency", command, 2'b01);
        wait_done(2000, ok);
        chk("t1_done_seen", ok, 1'b1);
        chk("t1_busy_in_done", busy, 1'b1);
        @(negedge clk);
        chk("t1_done_one_cycle", done, 1'b0);
        chk("t1_busy_cleared", busy, 1'b0);
        chk("t1_tx_count", tx_cnt - tx0, 3);
        chk("t1_done_count", done_cnt - d0, 1);
        chk("t1_gap_len", gap_len, 10);
        chk("t1_queue_empty", exp_q.size(), 0);

        // Empty frame
        a0 = pix_addr; d0 = done_cnt; tx0 = tx_cnt;
        pulse_start(0);
        chk("t2_done_pulse", done, 1'b1);
        chk("t2_command_idle", command, 2'b00);
        chk("t2_pix_addr_held", pix_addr, a0);
        @(negedge clk);
        chk("t2_done_cleared", done, 1'b0);
        chk("t2_busy_cleared", busy, 1'b0);
        chk("t2_pix_addr_still", pix_addr, a0);
        @(negedge clk);
        chk("t2_done_count", done_cnt - d0, 1);
        chk("t2_no_tx", tx_cnt - tx0, 0);

        // Start re-pulsed mid-frame, and start in the DONE cycle
        for (int i = 0; i < 4; i++) begin
            ram[i] = 24'h111111 * 24'(i + 1);
            exp_q.push_back(24'h111111 * 24'(i + 1));
        end
        tx0 = tx_cnt; d0 = done_cnt;
        pulse_start(4);
        repeat (8) @(negedge clk);
        pulse_start(1);
        repeat (15) @(negedge clk);
        pulse_start(2);
        wait_done(2000, ok);
        chk("t3_done_seen", ok, 1'b1);
        num_pixels = 4'd2;
        start      = 1'b1;
        @(negedge clk);
        start      = 1'b0;
        chk("t3_start_in_done_ignored", busy, 1'b0);
        repeat (5) @(negedge clk);
        chk("t3_still_idle", busy, 1'b0);
        chk("t3_tx_count", tx_cnt - tx0, 4);
        chk("t3_done_count", done_cnt - d0, 1);
        chk("t3_queue_empty", exp_q.size(), 0);

        // Reset in WAIT_LO of the second pixel of a five-pixel frame
        for (int i = 0; i < 5; i++) begin
            ram[i] = 24'h0A0B0C + 24'(i * 24'h101010);
            exp_q.push_back(24'h0A0B0C + 24'(i * 24'h101010));
        end
        tx0 = tx_cnt;
        pulse_start(5);
        ok = 1'b0;
        for (int k = 0; k < 2000; k++) begin
            @(posedge clk);
            if (tx_cnt - tx0 >= 2) begin
                ok = 1'b1;
                break;
            end
        end
        chk("t4_second_pixel_seen", ok, 1'b1);
        #1;
        chk("t4_in_tx_before_rst", command, 2'b01);
        rst = 1'b1;
        #1;
        chk("t4_rst_command", command, 2'b00);
        chk("t4_rst_busy", busy, 1'b0);
        chk("t4_rst_rgb", {r, g, b}, 24'h0);
        chk("t4_rst_pix_addr", pix_addr, 0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        exp_q.push_back(ram[0]); exp_q.push_back(ram[1]);
        tx0 = tx_cnt; d0 = done_cnt;
        pulse_start(2);
        wait_done(2000, ok);
        chk("t4_restart_done", ok, 1'b1);

        // Full-range frame (2^ADDR_W pixels), started in the IDLE cycle after DONE
        for (int i = 0; i < (1 << ADDR_W); i++) begin
            ram[i] = 24'hA00000 + 24'(i * 24'h010305);
            exp_q.push_back(24'hA00000 + 24'(i * 24'h010305));
        end
        pulse_start(1 << ADDR_W);
        chk("t5_start_after_done_accepted", busy, 1'b1);
        wait_done(4000, ok);
        chk("t5_done_seen", ok, 1'b1);
        @(negedge clk);
        chk("t5_tx_count", tx_cnt - tx0, 2 + (1 << ADDR_W));
        chk("t5_done_count", done_cnt - d0, 2);
        chk("t5_last_addr_no_wrap", pix_addr, (1 << ADDR_W) - 1);
        chk("t5_gap_len", gap_len, 10);
        chk("t5_queue_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
